// File: rtl/generic_pipe_reg_if.sv
// generic_pipe_reg_if: upstream and downstream valid/ready handshake bundle
// for the elastic pipeline register. The master side is the traffic source
// and sink around the pipeline. The slave side is the pipeline itself.
interface generic_pipe_reg_if #(
    parameter int WIDTH = 10
);
    logic                    in_valid;
    logic signed [WIDTH-1:0] in_data;
    logic                    in_ready;
    logic                    out_valid;
    logic signed [WIDTH-1:0] out_data;
    logic                    out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/generic_pipe_reg.sv
// generic_pipe_reg: DEPTH-stage elastic pipeline register for WIDTH-bit signed
// words. It tracks a valid bit per stage and collapses bubbles toward the
// output. It also supports a synchronous flush and keeps an occupancy count.
//
// Optional build macro GENERIC_PIPE_REG_ZERO_EN:
//   - When defined, any stage that ends the cycle empty also clears its data
//     register, so out_data reads 0 whenever out_valid is 0.
//   - When undefined, data registers load only on valid incoming words, so
//     out_data may show stale data while out_valid is low.
module generic_pipe_reg #(
    parameter  int WIDTH = 10,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    generic_pipe_reg_if.slave bus,
    output logic [CNT_W-1:0]  count
);

    logic [DEPTH-1:0]        v_q;
    logic [DEPTH-1:0]        v_d;
    logic signed [WIDTH-1:0] d_q [DEPTH];
    logic signed [WIDTH-1:0] d_d [DEPTH];
    logic [CNT_W-1:0]        count_q;
    logic [CNT_W-1:0]        count_d;

    logic [DEPTH-1:0]        adv;
    logic [DEPTH-1:0]        src_v;
    logic signed [WIDTH-1:0] src_d [DEPTH];
    logic                    in_ready;
    logic                    in_xfer;
    logic                    out_xfer;

    // Advance chain: a stage may load when it is empty or its successor moves on.
    always_comb begin
        logic a;
        a   = bus.out_ready;
        adv = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            a      = ~v_q[k] | a;
            adv[k] = a;
        end
    end

    // in_ready depends only on state, out_ready, flush and rst.
    // It never depends on in_valid, and it is held low during reset.
    assign in_ready      = adv[0] & ~flush & rst;
    assign in_xfer       = bus.in_valid & in_ready;
    assign out_xfer      = v_q[DEPTH-1] & bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = v_q[DEPTH-1];
    assign bus.out_data  = d_q[DEPTH-1];
    assign count         = count_q;

    // Word offered to each stage: the accepted input for stage 0, the predecessor otherwise.
    always_comb begin
        src_v[0] = in_xfer;
        src_d[0] = bus.in_data;
        for (int k = 1; k < DEPTH; k++) begin
            src_v[k] = v_q[k-1];
            src_d[k] = d_q[k-1];
        end
    end

    // Next stage state: flush empties everything, otherwise advancing stages take their source.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            v_d[k] = v_q[k];
            d_d[k] = d_q[k];
            if (flush) begin
                v_d[k] = 1'b0;
`ifdef GENERIC_PIPE_REG_ZERO_EN
                d_d[k] = '0;
`else
                d_d[k] = d_q[k];
`endif
            end else if (adv[k]) begin
                v_d[k] = src_v[k];
                if (src_v[k]) begin
                    d_d[k] = src_d[k];
                end else begin
`ifdef GENERIC_PIPE_REG_ZERO_EN
                    d_d[k] = '0;
`else
                    d_d[k] = d_q[k];
`endif
                end
            end
        end
    end

    // Occupancy: +1 per input transfer, -1 per output transfer, cleared by flush.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (in_xfer && !out_xfer) begin
            count_d = count_q + CNT_W'(1);
        end else if (!in_xfer && out_xfer) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Stage registers and count. Async reset clears valid, data and count together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q     <= '0;
            count_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            v_q     <= v_d;
            d_q     <= d_d;
            count_q <= count_d;
        end
    end

endmodule
